wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and a
//  long-latency unit (mul/div, late loads). WB results never stall; unit results queue
//  in a small FIFO and drain in cycles where WB does not write. Sits after WRITEBACK,
//  driving the register-file write port.
// PARAMETERS
//  DATA_W        32  write-data width
//  ADDR_W        5   register address width
//  DEPTH         2   pending-result FIFO entries (>=1)
//  STARVE_LIMIT  4   consecutive lost arbitration cycles before hold (WB_STARVE_GUARD_EN only)
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  wb_regwrite   in   1        WB stage write request (MEM_WB_regwrite)
//  wb_rd         in   ADDR_W   WB destination register
//  wb_data       in   DATA_W   WB result (WriteData)
//  lu_valid      in   1        long-latency result valid
//  lu_rd         in   ADDR_W   long-latency destination register
//  lu_data       in   DATA_W   long-latency result
//  lu_ready      out  1        FIFO can accept; transfer = lu_valid & lu_ready
//  rf_we         out  1        register-file write enable (registered)
//  rf_waddr      out  ADDR_W   register-file write address (registered)
//  rf_wdata      out  DATA_W   register-file write data (registered)
//  pend_count    out  $clog2(DEPTH+1)  entries currently queued
//  ovf_err       out  1        sticky: lu_valid seen while lu_ready=0
//  hold_pipe     out  1        request one pipeline bubble (0 when guard compiled out)
// BEHAVIOUR
//  - Reset (sync, clk edge with rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, FIFO flushed,
//    pend_count=0, ovf_err=0, hold_pipe=0, starve counter=0. Reset mid-drain discards queue.
//  - lu_ready = (pend_count < DEPTH), from registered count; no same-cycle pass-through
//    when full even if a pop occurs that cycle.
//  - Writes to register 0 are dropped: wb_rd==0 counts as no WB request; lu_rd==0 transfer
//    is accepted (lu_ready honoured) but not enqueued.
//  - Arbitration per cycle, fixed priority: (1) WB request -> rf_* <= wb_*, rf_we<=1;
//    (2) else FIFO non-empty -> rf_* <= head, pop, rf_we<=1; (3) else rf_we<=0, addr/data hold.
//  - Latency: WB 1 cycle; unit result >=2 cycles (enqueue edge, then earliest pop edge).
//  - Push and pop same cycle: pend_count unchanged; FIFO order preserved (oldest first).
//  - FIFO pointers wrap modulo DEPTH; count never exceeds DEPTH; push ignored when full.
//  - Overflow: lu_valid & !lu_ready sets ovf_err, held until rst; data dropped.
//  - WAW ordering between WB and queued results is the hazard unit's responsibility;
//    this block writes in arbitration order only.
// CONFIGURATION
//  WB_STARVE_GUARD_EN defined: starve counter increments each cycle FIFO non-empty and
//   WB wins; clears on any pop or empty FIFO. When counter == STARVE_LIMIT-1 and WB wins
//   again, hold_pipe <= 1 for exactly one cycle and counter clears; upstream then delivers
//   wb_regwrite=0 the next cycle, so the head drains. hold_pipe never asserted twice in a row.
//  Not defined: no counter logic; hold_pipe tied 0; queued results may starve indefinitely.
// TESTING
//  1 rst high 2 cycles with lu_valid=1 -> all outputs 0, pend_count=0, nothing written after.
//  2 wb_regwrite=1 rd=5 data=0xDEADBEEF, no lu -> next cycle rf_we=1 waddr=5 wdata=0xDEADBEEF.
//  3 same cycle WB rd=3 data=1 and lu rd=7 data=2 -> cycle+1 writes r3=1, cycle+2 writes r7=2.
//  4 DEPTH=2, WB busy every cycle, lu pushes 3 results -> lu_ready=0 after 2, 3rd sets ovf_err
//    =1; WB idle -> the 2 queued entries drain in push order, pend_count 2->1->0.
//  5 wb_rd=0 with wb_regwrite=1 while FIFO holds r9 -> r9 written that cycle, no write to r0.
//  6 guard on, STARVE_LIMIT=4, WB continuous with 1 queued -> hold_pipe=1 one cycle after 4th
//    loss; with wb_regwrite=0 next cycle queued entry written; guard off -> hold_pipe stays 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order WB
// stage (always wins) and a long-latency unit whose results wait in a small FIFO.
// Optional macro WB_STARVE_GUARD_EN adds a starvation counter that requests a
// one-cycle pipeline bubble (hold_pipe) so a queued result can drain.
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_regwrite,
    input  logic [ADDR_W-1:0]          wb_rd,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       lu_valid,
    input  logic [ADDR_W-1:0]          lu_rd,
    input  logic [DATA_W-1:0]          lu_data,
    output logic                       lu_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0] pend_count,
    output logic                       ovf_err,
    output logic                       hold_pipe
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              ovf_q, ovf_d;

    logic wb_req;
    logic fifo_nempty;
    logic push;
    logic pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Request decode: writes to r0 are dropped; readiness comes from the registered count only.
    always_comb begin
        wb_req      = wb_regwrite && (wb_rd != '0);
        fifo_nempty = (cnt_q != '0);
        lu_ready    = (cnt_q < DEPTH_C);
        push        = lu_valid && lu_ready && (lu_rd != '0);
        pop         = !wb_req && fifo_nempty;
    end

    // Fixed-priority write-port selection: WB, then FIFO head, else idle with addr/data held.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
        end else if (pop) begin
            rf_we_d                  = 1'b1;
            {rf_waddr_d, rf_wdata_d} = mem_q[rd_ptr_q];
        end
    end

    // FIFO bookkeeping plus sticky overflow flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {lu_rd, lu_data};
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q || (lu_valid && !lu_ready);
    end

    // State registers with synchronous reset; reset discards anything still queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int SC_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STARVE_LIMIT - 1);

    logic [SC_W-1:0] starve_q, starve_d;
    logic            hold_q, hold_d;

    // Count cycles the queued head loses to WB; on the limit, request one bubble.
    // A bubble just issued blocks an immediate repeat (matters only for STARVE_LIMIT=1).
    always_comb begin
        starve_d = '0;
        hold_d   = 1'b0;
        if (wb_req && fifo_nempty) begin
            if (starve_q == SC_LAST) begin
                hold_d   = !hold_q;
                starve_d = hold_q ? starve_q : '0;
            end else begin
                starve_d = starve_q + SC_W'(1);
            end
        end
    end

    // Starvation state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    assign hold_pipe = hold_q;
`else
    assign hold_pipe = 1'b0;
`endif

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign pend_count = cnt_q;
    assign ovf_err    = ovf_q;

endmodule
